// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite animation fetch block.
package sprite_pkg;

  localparam int          SPR_W       = 32;
  localparam int          SPR_H       = 32;
  localparam int          NUM_FRAMES  = 4;
  localparam int          FRAME_TICKS = 8;
  localparam int          ADDR_W      = 19;
  localparam logic [23:0] TRANSP_RGB  = 24'hfffed2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } anim_state_t;

endpackage

// File: rtl/sprite_anim_seq.sv
// Animation sequencer: walks frames 0..NUM_FRAMES-1, each held for FRAME_TICKS
// vsync pulses, then parks on the last frame until the next start pulse.
// Frame only advances on vsync_tick so a scan never shows two frames.
module sprite_anim_seq
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES  = sprite_pkg::NUM_FRAMES,
  parameter int FRAME_TICKS = sprite_pkg::FRAME_TICKS,
  parameter int FRAME_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic               vsync_tick,
  output logic [FRAME_W-1:0] frame,
  output anim_state_t        state,
  output logic               busy,
  output logic               done
);

  localparam int                 TICK_W     = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(FRAME_TICKS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(NUM_FRAMES - 1);

  anim_state_t        state_reg, state_next;
  logic [FRAME_W-1:0] frame_reg, frame_next;
  logic [TICK_W-1:0]  tick_reg, tick_next;
  logic               busy_reg, done_reg;

  // State, counters and registered status flags
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
      frame_reg <= '0;
      tick_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      frame_reg <= frame_next;
      tick_reg  <= tick_next;
      busy_reg  <= (state_next == PLAY);
      done_reg  <= (state_next == DONE);
    end
  end

  // Next-state logic; start always wins over a coincident vsync_tick
  always_comb begin
    state_next = state_reg;
    frame_next = frame_reg;
    tick_next  = tick_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = PLAY;
          frame_next = '0;
          tick_next  = '0;
        end
      end
      PLAY: begin
        if (start) begin
          frame_next = '0;
          tick_next  = '0;
        end else if (vsync_tick) begin
          if (tick_reg == TICK_LAST) begin
            tick_next = '0;
            if (frame_reg == FRAME_LAST) begin
              state_next = DONE;
            end else begin
              frame_next = frame_reg + FRAME_W'(1);
            end
          end else begin
            tick_next = tick_reg + TICK_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign frame = frame_reg;
  assign state = state_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: rtl/sprite_anim_fetch.sv
// Sprite animation fetch: turns the VGA scan position into frame-RAM read
// addresses for the current animation frame and produces a keyed pixel colour
// three clocks later. Optional macro SPRITE_MIRROR_EN adds a flip_x input
// that mirrors the sprite horizontally.
module sprite_anim_fetch
  import sprite_pkg::*;
#(
  parameter int          SPR_W       = sprite_pkg::SPR_W,
  parameter int          SPR_H       = sprite_pkg::SPR_H,
  parameter int          NUM_FRAMES  = sprite_pkg::NUM_FRAMES,
  parameter int          FRAME_TICKS = sprite_pkg::FRAME_TICKS,
  parameter logic [23:0] TRANSP_RGB  = sprite_pkg::TRANSP_RGB
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              vsync_tick,
  input  logic              start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        PosX,
  input  logic [9:0]        PosY,
`ifdef SPRITE_MIRROR_EN
  input  logic              flip_x,
`endif
  output logic [ADDR_W-1:0] read_address,
  input  logic [23:0]       rom_data,
  output logic [23:0]       pixel_rgb,
  output logic              pixel_on,
  output logic              busy,
  output logic              done
);

  localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  logic [FRAME_W-1:0] frame;
  anim_state_t        state;

  sprite_anim_seq #(
    .NUM_FRAMES  (NUM_FRAMES),
    .FRAME_TICKS (FRAME_TICKS),
    .FRAME_W     (FRAME_W)
  ) u_seq (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .start      (start),
    .vsync_tick (vsync_tick),
    .frame      (frame),
    .state      (state),
    .busy       (busy),
    .done       (done)
  );

  // 11-bit compares so a sprite hanging off the right/bottom edge never wraps
  logic [10:0] draw_x_ext, draw_y_ext, pos_x_ext, pos_y_ext;
  logic [10:0] dx_full, dy_full;
  logic        in_box_next;
  logic [ADDR_W-1:0] col_idx, addr_next;

  assign draw_x_ext = {1'b0, DrawX};
  assign draw_y_ext = {1'b0, DrawY};
  assign pos_x_ext  = {1'b0, PosX};
  assign pos_y_ext  = {1'b0, PosY};
  assign dx_full    = draw_x_ext - pos_x_ext;
  assign dy_full    = draw_y_ext - pos_y_ext;

  assign in_box_next = (draw_x_ext >= pos_x_ext) && (draw_x_ext < pos_x_ext + 11'(SPR_W)) &&
                       (draw_y_ext >= pos_y_ext) && (draw_y_ext < pos_y_ext + 11'(SPR_H));

`ifdef SPRITE_MIRROR_EN
  assign col_idx = flip_x ? (ADDR_W'(SPR_W - 1) - ADDR_W'(dx_full)) : ADDR_W'(dx_full);
`else
  assign col_idx = ADDR_W'(dx_full);
`endif

  // Outside the box the address is parked at 0 so off-screen words are never read
  assign addr_next = in_box_next ?
                     (ADDR_W'(frame) * ADDR_W'(SPR_W * SPR_H) +
                      ADDR_W'(dy_full) * ADDR_W'(SPR_W) + col_idx) : '0;

  logic [ADDR_W-1:0] read_address_reg;
  logic              in_box_d1_reg, in_box_d2_reg;
  logic              pixel_on_reg;
  logic [23:0]       pixel_rgb_reg;
  logic              pixel_on_next;

  assign pixel_on_next = in_box_d2_reg && (state != IDLE) && (rom_data != TRANSP_RGB);

  // Three-stage pipeline: address issue, RAM read (in_box delayed), colour key
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_address_reg <= '0;
      in_box_d1_reg    <= 1'b0;
      in_box_d2_reg    <= 1'b0;
      pixel_on_reg     <= 1'b0;
      pixel_rgb_reg    <= '0;
    end else begin
      read_address_reg <= addr_next;
      in_box_d1_reg    <= in_box_next;
      in_box_d2_reg    <= in_box_d1_reg;
      pixel_on_reg     <= pixel_on_next;
      pixel_rgb_reg    <= pixel_on_next ? rom_data : 24'h0;
    end
  end

  assign read_address = read_address_reg;
  assign pixel_on     = pixel_on_reg;
  assign pixel_rgb    = pixel_rgb_reg;

endmodule

// File: tb/tb_sprite_anim_fetch.sv
// Self-checking bench for sprite_anim_fetch (default parameters). Build with
// SPRITE_MIRROR_EN defined to exercise the flip_x port.
module tb_sprite_anim_fetch;

  localparam int          W  = 32;
  localparam int          H  = 32;
  localparam int          NF = 4;
  localparam int          FT = 8;
  localparam logic [23:0] KEY = 24'hfffed2;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        vsync_tick = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, PosX = '0, PosY = '0;
`ifdef SPRITE_MIRROR_EN
  logic        flip_x = 1'b0;
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif
  logic [18:0] read_address;
  logic [23:0] rom_data;
  logic [23:0] pixel_rgb;
  logic        pixel_on, busy, done;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  sprite_anim_fetch dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .vsync_tick   (vsync_tick),
    .start        (start),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .PosX         (PosX),
    .PosY         (PosY),
`ifdef SPRITE_MIRROR_EN
    .flip_x       (flip_x),
`endif
    .read_address (read_address),
    .rom_data     (rom_data),
    .pixel_rgb    (pixel_rgb),
    .pixel_on     (pixel_on),
    .busy         (busy),
    .done         (done)
  );

  // Frame-RAM contents: distinct colours, every address ending in 3'b111 keyed out
  function automatic logic [23:0] ram_word(input logic [18:0] a);
    if (a[2:0] == 3'b111) return KEY;
    return 24'h100000 + {5'b0, a};
  endfunction

  // Frame RAM with one clock of read latency
  always @(posedge Clk) rom_data <= ram_word(read_address);

  // ---------------- reference model ----------------
  typedef struct {
    bit          inb;
    logic [18:0] addr;
  } pe_t;

  bit  m_started;
  int  m_ticks;     // vsync pulses seen since the last start, saturating at NF*FT
  pe_t pq[$];       // the two most recent issued lookups, oldest first

  task automatic model_reset();
    m_started = 1'b0;
    m_ticks   = 0;
    pq.delete();
    pq.push_back('{1'b0, 19'd0});
    pq.push_back('{1'b0, 19'd0});
  endtask

  function automatic int m_frame();
    return (m_ticks / FT > NF - 1) ? NF - 1 : m_ticks / FT;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus, model update and comparison of every output
  task automatic step(input bit st, input bit vs, input logic [9:0] dx_, input logic [9:0] dy_,
                      input logic [9:0] px, input logic [9:0] py, input bit fx);
    int          ix, iy, ipx, ipy, col;
    bit          inb, act, epon;
    logic [18:0] a;
    pe_t         old;
    start = st; vsync_tick = vs;
    DrawX = dx_; DrawY = dy_; PosX = px; PosY = py;
`ifdef SPRITE_MIRROR_EN
    flip_x = fx;
`endif
    @(posedge Clk);
    ix = int'(dx_); iy = int'(dy_); ipx = int'(px); ipy = int'(py);
    inb = (ix >= ipx) && (ix < ipx + W) && (iy >= ipy) && (iy < ipy + H);
    col = (MIRROR && fx) ? (W - 1 - (ix - ipx)) : (ix - ipx);
    a   = inb ? 19'(m_frame() * W * H + (iy - ipy) * W + col) : 19'd0;
    old = pq.pop_front();
    pq.push_back('{inb, a});
    act  = m_started;
    epon = old.inb && act && (ram_word(old.addr) != KEY);
    if (st) begin
      m_started = 1'b1;
      m_ticks   = 0;
    end else if (vs && m_started && m_ticks < NF * FT) begin
      m_ticks++;
    end
    #1;
    start = 1'b0; vsync_tick = 1'b0;
    chk("addr", read_address, a);
    chk("pixel_on", pixel_on, epon);
    chk("pixel_rgb", pixel_rgb, epon ? ram_word(old.addr) : 24'h0);
    chk("busy", busy, m_started && m_ticks < NF * FT);
    chk("done", done, m_started && m_ticks >= NF * FT);
    $display("step t=%0t st=%0d vs=%0d X=%0d Y=%0d P=(%0d,%0d) addr=%0d on=%0d rgb=%h busy=%0d done=%0d",
             $time, st, vs, dx_, dy_, px, py, read_address, pixel_on, pixel_rgb, busy, done);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_addr"}, read_address, 0);
    chk({nm, "_on"}, pixel_on, 0);
    chk({nm, "_rgb"}, pixel_rgb, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  typedef struct {
    logic [9:0]  dx, dy, px, py;
    logic [18:0] exp_addr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    // address vectors, all evaluated while frame 2 is showing
    tbl[0] = '{10'd105, 10'd53,  10'd100, 10'd50,  19'd2149};  // 2048+96+5
    tbl[1] = '{10'd639, 10'd50,  10'd620, 10'd50,  19'd2067};  // right edge, dx=19
    tbl[2] = '{10'd5,   10'd50,  10'd620, 10'd50,  19'd0};     // left of box
    tbl[3] = '{10'd110, 10'd82,  10'd100, 10'd50,  19'd0};     // one row below box
    tbl[4] = '{10'd131, 10'd81,  10'd100, 10'd50,  19'd3071};  // last pixel of box
    tbl[5] = '{10'd0,   10'd479, 10'd0,   10'd470, 19'd2336};  // bottom edge, dy=9

    model_reset();
    #2 Reset_n = 1'b0;
    #1 check_all_zero("por");
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset_n = 1'b1;

    // sequencing: start, then 32 vsync pulses through all frames
    step(1, 0, 10'd100, 10'd50, 10'd100, 10'd50, 0);
    for (int i = 0; i < NF * FT; i++) begin
      step(0, 1, 10'(100 + (i % W)), 10'(50 + i), 10'd100, 10'd50, 0);
      step(0, 0, 10'(101 + (i % W)), 10'(50 + i), 10'd100, 10'd50, 0);
    end
    chk("seq_done", done, 1);
    chk("seq_busy", busy, 0);
    step(0, 1, 10'd100, 10'd50, 10'd100, 10'd50, 0);
    chk("done_hold_addr", read_address, 19'd3072);  // still last frame

    // address table at frame 2
    step(1, 0, 10'd0, 10'd0, 10'd100, 10'd50, 0);
    for (int i = 0; i < 2 * FT; i++) step(0, 1, 10'd0, 10'd0, 10'd100, 10'd50, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, tbl[i].dx, tbl[i].dy, tbl[i].px, tbl[i].py, 0);
      chk("tbl_addr", read_address, tbl[i].exp_addr);
    end

    // start colliding with vsync in frame 3
    for (int i = 0; i < FT; i++) step(0, 1, 10'd0, 10'd0, 10'd100, 10'd50, 0);
    step(0, 0, 10'd103, 10'd50, 10'd100, 10'd50, 0);
    chk("frame3_addr", read_address, 19'd3075);
    step(1, 1, 10'd103, 10'd50, 10'd100, 10'd50, 0);
    chk("collide_busy", busy, 1);
    step(0, 0, 10'd103, 10'd50, 10'd100, 10'd50, 0);
    chk("collide_addr", read_address, 19'd3);
    for (int i = 0; i < FT - 1; i++) step(0, 1, 10'd103, 10'd50, 10'd100, 10'd50, 0);
    step(0, 0, 10'd103, 10'd50, 10'd100, 10'd50, 0);
    chk("collide_tick0", read_address, 19'd3);
    step(0, 1, 10'd103, 10'd50, 10'd100, 10'd50, 0);
    step(0, 0, 10'd103, 10'd50, 10'd100, 10'd50, 0);
    chk("collide_frame1", read_address, 19'd1027);

    // transparency key, frame 1: dx=7 keyed out, dx=6 visible
    repeat (3) step(0, 0, 10'd107, 10'd50, 10'd100, 10'd50, 0);
    chk("transp_on", pixel_on, 0);
    chk("transp_rgb", pixel_rgb, 0);
    repeat (3) step(0, 0, 10'd106, 10'd50, 10'd100, 10'd50, 0);
    chk("opaque_on", pixel_on, 1);
    chk("opaque_rgb", pixel_rgb, 24'h100000 + 24'd1030);

    // horizontal mirror at frame 0, top-left pixel
    step(1, 0, 10'd0, 10'd0, 10'd200, 10'd100, 0);
    step(0, 0, 10'd200, 10'd100, 10'd200, 10'd100, 1);
    chk("mirror_addr", read_address, MIRROR ? 19'd31 : 19'd0);

    // asynchronous reset in the middle of a frame
    step(0, 0, 10'd201, 10'd100, 10'd200, 10'd100, 0);
    step(0, 0, 10'd202, 10'd100, 10'd200, 10'd100, 0);
    #2 Reset_n = 1'b0;
    #1 check_all_zero("rst");
    @(negedge Clk) Reset_n = 1'b1;
    model_reset();
    step(1, 0, 10'd202, 10'd100, 10'd200, 10'd100, 0);
    chk("rst_pon1", pixel_on, 0);
    step(0, 0, 10'd202, 10'd100, 10'd200, 10'd100, 0);
    chk("rst_pon2", pixel_on, 0);
    step(0, 0, 10'd202, 10'd100, 10'd200, 10'd100, 0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [9:0] px, py, dx, dy;
      px = 10'($urandom_range(0, 639));
      py = 10'($urandom_range(0, 479));
      if ($urandom_range(0, 7) == 0) begin
        dx = 10'($urandom_range(0, 1023));
        dy = 10'($urandom_range(0, 1023));
      end else begin
        dx = 10'(int'(px) + $urandom_range(0, 40));
        dy = 10'(int'(py) + $urandom_range(0, 40));
      end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, dx, dy, px, py,
           1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
